// File: rtl/iram_pkg.sv
// ---------------------------------------------------------------------------
// iram_pkg
// Shared definitions for the instruction-RAM loader/arbiter:
//   - IRAM_DEPTH / IRAM_WORD_W : default storage geometry (128 x 16)
//   - NOP_WORD                 : word presented to the CPU while it is stalled
//   - ld_state_e               : loader FSM state encoding
//   - accepts_bytes()          : states in which a load byte may transfer
// Optional feature macro: IRAM_LOAD_CHECKSUM_EN adds the CK_HI/CK_LO states.
// ---------------------------------------------------------------------------
package iram_pkg;

  localparam int          IRAM_DEPTH  = 128;
  localparam int          IRAM_WORD_W = 16;
  localparam logic [15:0] NOP_WORD    = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
`ifdef IRAM_LOAD_CHECKSUM_EN
    DONE,
    CK_HI,
    CK_LO
`else
    DONE
`endif
  } ld_state_e;

  // A load byte can only be taken while the FSM is waiting for one.
  function automatic logic accepts_bytes(input ld_state_e s);
    logic ok;
    ok = 1'b0;
    case (s)
      HI, LO: ok = 1'b1;
`ifdef IRAM_LOAD_CHECKSUM_EN
      CK_HI, CK_LO: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/iram_loader_arb_if.sv
// ---------------------------------------------------------------------------
// iram_loader_arb_if
// Bundles the CPU fetch port and the byte-serial program-load port.
//   CPU side : CPU_ADDR (byte address in), CPU_Q (word out), CPU_STALL (out)
//   Load side: LD_START, LD_VALID, LD_DATA, LD_LAST (in);
//              LD_READY, LD_DONE, LD_ERR, WORDS_LOADED (out)
// Modports:
//   master - the environment (CPU + loader source) driving the block
//   slave  - the iram_loader_arb block itself
// ---------------------------------------------------------------------------
interface iram_loader_arb_if;

  logic [7:0]  CPU_ADDR;
  logic [15:0] CPU_Q;
  logic        CPU_STALL;

  logic        LD_START;
  logic        LD_VALID;
  logic [7:0]  LD_DATA;
  logic        LD_LAST;
  logic        LD_READY;
  logic        LD_DONE;
  logic        LD_ERR;
  logic [7:0]  WORDS_LOADED;

  modport master (
    output CPU_ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST,
    input  CPU_Q, CPU_STALL, LD_READY, LD_DONE, LD_ERR, WORDS_LOADED
  );

  modport slave (
    input  CPU_ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST,
    output CPU_Q, CPU_STALL, LD_READY, LD_DONE, LD_ERR, WORDS_LOADED
  );

endinterface

// File: rtl/iram_array.sv
// ---------------------------------------------------------------------------
// iram_array
// Instruction storage: DEPTH words of WORD_W bits.
//   clk   : write clock
//   we    : write enable, word stored on the rising edge of clk
//   waddr : write word index
//   wdata : write data
//   raddr : read word index (asynchronous read, zero latency)
//   rdata : read data
// The array has no reset: its contents survive a block reset.
// ---------------------------------------------------------------------------
module iram_array
  import iram_pkg::*;
#(
  parameter int DEPTH  = IRAM_DEPTH,
  parameter int WORD_W = IRAM_WORD_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The CPU fetches in the same cycle it presents the address.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/iram_loader_arb.sv
// ---------------------------------------------------------------------------
// iram_loader_arb
// Instruction RAM shared between a CPU fetch port and a byte-serial program
// loader. While idle the CPU reads the RAM combinationally; during a load
// session the CPU is stalled and sees NOP_WORD.
//
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   RESET : asynchronous active-high reset (memory contents are kept)
//   bus   : iram_loader_arb_if.slave (CPU fetch + load handshake)
//
// Load protocol: each word arrives high byte first, then low byte. LD_LAST
// is sampled only with the low byte. After every complete word one WRITE
// cycle stores it at the current pointer. A session ends in DONE (one-cycle
// LD_DONE) either on LAST or when the array is full without LAST (error).
//
// Optional feature macro: IRAM_LOAD_CHECKSUM_EN
//   When defined, a LAST session is followed by a 16-bit checksum (two
//   bytes, high first) compared with the mod-2^16 sum of all words written;
//   a mismatch raises LD_ERR.
// ---------------------------------------------------------------------------
module iram_loader_arb
  import iram_pkg::*;
#(
  parameter int DEPTH  = IRAM_DEPTH,
  parameter int WORD_W = IRAM_WORD_W
) (
  input logic           CLK,
  input logic           RESET,
  iram_loader_arb_if.slave bus
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  ld_state_e          state_q, state_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [7:0]         hi_q,    hi_d;
  logic [7:0]         lo_q,    lo_d;
  logic               last_q,  last_d;
  logic               err_q,   err_d;
  logic [7:0]         words_q, words_d;
`ifdef IRAM_LOAD_CHECKSUM_EN
  logic [15:0]        sum_q,   sum_d;
  logic [7:0]         ck_hi_q, ck_hi_d;
`endif

  logic               ld_ready;
  logic               byte_xfer;
  logic               start_ok;
  logic               mem_we;
  logic [15:0]        wr_word;
  logic [WORD_W-1:0]  rd_word;
  logic [PTR_W-1:0]   rd_idx;
  logic               unused_addr_lsb;

  assign ld_ready  = accepts_bytes(state_q);
  assign byte_xfer = bus.LD_VALID && ld_ready;
  assign wr_word   = {hi_q, lo_q};

  // A start pulse opens a session from IDLE and restarts one that is still
  // collecting a word; once a word is being committed it is ignored.
  assign start_ok  = bus.LD_START &&
                     ((state_q == IDLE) || (state_q == HI) || (state_q == LO));

  // ------------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------------
  assign rd_idx          = PTR_W'(bus.CPU_ADDR[7:1]);
  assign unused_addr_lsb = bus.CPU_ADDR[0];

  iram_array #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .ADDR_W (PTR_W)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (ptr_q),
    .wdata (WORD_W'(wr_word)),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
`ifdef IRAM_LOAD_CHECKSUM_EN
      sum_q   <= '0;
      ck_hi_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
      err_q   <= err_d;
      words_q <= words_d;
`ifdef IRAM_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
      ck_hi_q <= ck_hi_d;
`endif
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    last_d  = last_q;
    err_d   = err_q;
    words_d = words_q;
    mem_we  = 1'b0;
`ifdef IRAM_LOAD_CHECKSUM_EN
    sum_d   = sum_q;
    ck_hi_d = ck_hi_q;
`endif

    if (start_ok) begin
      // Fresh session: any half-collected word is dropped, never written.
      state_d = HI;
      ptr_d   = '0;
      hi_d    = '0;
      lo_d    = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
      words_d = '0;
`ifdef IRAM_LOAD_CHECKSUM_EN
      sum_d   = '0;
      ck_hi_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        HI: begin
          // LAST is meaningless on a high byte and is not sampled here.
          if (byte_xfer) begin
            hi_d    = bus.LD_DATA;
            state_d = LO;
          end
        end

        LO: begin
          if (byte_xfer) begin
            lo_d    = bus.LD_DATA;
            last_d  = bus.LD_LAST;
            state_d = WRITE;
          end
        end

        WRITE: begin
          mem_we  = 1'b1;
          words_d = words_q + 8'd1;
`ifdef IRAM_LOAD_CHECKSUM_EN
          sum_d   = sum_q + wr_word;
`endif
          if (last_q) begin
`ifdef IRAM_LOAD_CHECKSUM_EN
            state_d = CK_HI;
`else
            state_d = DONE;
`endif
          end else if (ptr_q == PTR_LAST) begin
            // Array full and no LAST seen: stop instead of wrapping to 0.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = HI;
          end
        end

`ifdef IRAM_LOAD_CHECKSUM_EN
        CK_HI: begin
          if (byte_xfer) begin
            ck_hi_d = bus.LD_DATA;
            state_d = CK_LO;
          end
        end

        CK_LO: begin
          if (byte_xfer) begin
            if ({ck_hi_q, bus.LD_DATA} != sum_q) begin
              err_d = 1'b1;
            end
            state_d = DONE;
          end
        end
`endif

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.CPU_STALL    = (state_q != IDLE);
  assign bus.CPU_Q        = (state_q == IDLE) ? 16'(rd_word) : NOP_WORD;
  assign bus.LD_READY     = ld_ready;
  assign bus.LD_DONE      = (state_q == DONE);
  assign bus.LD_ERR       = err_q;
  assign bus.WORDS_LOADED = words_q;

endmodule

// File: tb/tb_iram_loader_arb.sv
// ---------------------------------------------------------------------------
// tb_iram_loader_arb
// Scoreboard bench for iram_loader_arb. Stimulus tasks push the expected
// session outcome (words loaded, error flag) and expected fetch words into
// queues; a monitor pops and compares them when the DUT raises LD_DONE or
// when a CPU fetch is presented. A plain array holds the reference memory.
// Define IRAM_LOAD_CHECKSUM_EN to exercise the checksum variant.
// ---------------------------------------------------------------------------
module tb_iram_loader_arb;
  import iram_pkg::*;

  typedef struct {
    int words;
    bit err;
  } done_rec_t;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  iram_loader_arb_if bus ();

  iram_loader_arb #(
    .DEPTH  (128),
    .WORD_W (16)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] ref_mem [128];
  done_rec_t   done_exp [$];
  logic [15:0] rd_exp [$];
  logic [15:0] sess_words [$];
  bit          rd_req = 1'b0;
  done_rec_t   mon_rec;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ------------------------------------------------------------------------
  // Monitor / scoreboard
  // ------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.CPU_STALL) begin
        chk("stalled_q_is_nop", bus.CPU_Q, 32'(NOP_WORD));
      end
      if (bus.LD_DONE) begin
        if (done_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got LD_DONE=1, expected no session end at %0t", $time);
        end else begin
          mon_rec = done_exp.pop_front();
          chk("done_words_loaded", bus.WORDS_LOADED, mon_rec.words);
          chk("done_err", bus.LD_ERR, 32'(mon_rec.err));
        end
      end
      if (rd_req) begin
        chk("fetch_stall", bus.CPU_STALL, 0);
        if (rd_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL fetch_underflow: got fetch, expected none at %0t", $time);
        end else begin
          chk("fetch_data", bus.CPU_Q, rd_exp.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising edge)
  // ------------------------------------------------------------------------
  task automatic pulse_start();
    bus.LD_START = 1'b1;
    @(posedge CLK); #1;
    bus.LD_START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int  budget;
    bit  rdy;
    repeat ($urandom_range(0, 2)) begin
      @(posedge CLK); #1;
    end
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = d;
    bus.LD_LAST  = last;
    bus.CPU_ADDR = 8'($urandom);
    budget = 0;
    forever begin
      @(negedge CLK);
      rdy = bus.LD_READY;
      @(posedge CLK); #1;
      if (rdy) break;
      budget++;
      if (budget > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_timeout: got LD_READY=0 for 50 cycles, expected 1 at %0t", $time);
        break;
      end
    end
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    bus.LD_DATA  = 8'($urandom);
  endtask

  task automatic send_ck(input logic [15:0] ck);
    send_byte(ck[15:8], 1'($urandom));
    send_byte(ck[7:0], 1'($urandom));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    forever begin
      @(negedge CLK);
      if (!bus.CPU_STALL) break;
      k++;
      if (k > 40) begin
        vectors++;
        miscompares++;
        $display("FAIL idle_timeout: got CPU_STALL=1 for 40 cycles, expected 0 at %0t", $time);
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_read(input logic [7:0] a);
    bus.CPU_ADDR = a;
    rd_exp.push_back(ref_mem[a[7:1]]);
    rd_req = 1'b1;
    @(negedge CLK); #1;
    rd_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Runs a session over sess_words. last_idx < 0 means no LAST is sent and
  // the array is expected to fill up (sess_words must then hold >= 128).
  task automatic run_session(input int last_idx, input bit bad_ck, input bit do_start);
    int          n_wr;
    bit          exp_err;
    logic [15:0] sum;
    done_rec_t   r;
    sum = 16'h0000;
    if (last_idx >= 0) begin
      n_wr    = last_idx + 1;
      exp_err = 1'b0;
    end else begin
      n_wr    = (sess_words.size() > 128) ? 128 : sess_words.size();
      exp_err = 1'b1;
    end
    for (int i = 0; i < n_wr; i++) begin
      sum = sum + sess_words[i];
      ref_mem[i] = sess_words[i];
    end
`ifdef IRAM_LOAD_CHECKSUM_EN
    if (last_idx >= 0) exp_err = bad_ck;
`endif
    r.words = n_wr;
    r.err   = exp_err;
    done_exp.push_back(r);
    if (do_start) pulse_start();
    for (int i = 0; i < n_wr; i++) begin
      send_byte(sess_words[i][15:8], 1'($urandom));
      send_byte(sess_words[i][7:0], (i == last_idx));
    end
`ifdef IRAM_LOAD_CHECKSUM_EN
    if (last_idx >= 0) send_ck(bad_ck ? sum + 16'h0001 : sum);
`endif
    wait_idle();
  endtask

  // ------------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------------
  initial begin
    logic [15:0] w;
    int          n;

    RESET        = 1'b1;
    bus.CPU_ADDR = 8'h00;
    bus.LD_START = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_DATA  = 8'h00;
    bus.LD_LAST  = 1'b0;

    // Reset state
    #12;
    chk("rst_stall", bus.CPU_STALL, 0);
    chk("rst_ready", bus.LD_READY, 0);
    chk("rst_done", bus.LD_DONE, 0);
    chk("rst_err", bus.LD_ERR, 0);
    chk("rst_words", bus.WORDS_LOADED, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Fill the whole array with no LAST: overflow error, no wrap.
    sess_words.delete();
    for (int i = 0; i < 130; i++) sess_words.push_back(16'($urandom));
    run_session(-1, 1'b0, 1'b1);
    for (int i = 0; i < 128; i++) do_read({i[6:0], 1'($urandom)});

    // Three words, LAST on the sixth byte.
    sess_words = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    run_session(2, 1'b0, 1'b1);
    do_read(8'h04);
    do_read(8'h00);
    do_read(8'h03);
    do_read(8'h05);
    do_read(8'h06);

    // Ten idle cycles between the bytes of a word.
    begin
      done_rec_t r;
      r.words = 1;
      r.err   = 1'b0;
      done_exp.push_back(r);
      ref_mem[0] = 16'h1357;
      pulse_start();
      send_byte(8'h13, 1'b1);
      repeat (10) begin
        @(negedge CLK);
        chk("gap_ready", bus.LD_READY, 1);
        chk("gap_stall", bus.CPU_STALL, 1);
        chk("gap_words", bus.WORDS_LOADED, 0);
      end
      @(posedge CLK); #1;
      send_byte(8'h57, 1'b1);
`ifdef IRAM_LOAD_CHECKSUM_EN
      send_ck(16'h1357);
`endif
      wait_idle();
      do_read(8'h00);
      do_read(8'h02);
    end

    // Reset between the high and low byte of the second word.
    pulse_start();
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'h99, 1'b0);
    ref_mem[0] = 16'hBEEF;
    RESET = 1'b1;
    #1;
    chk("midrst_stall", bus.CPU_STALL, 0);
    chk("midrst_ready", bus.LD_READY, 0);
    chk("midrst_done", bus.LD_DONE, 0);
    chk("midrst_words", bus.WORDS_LOADED, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    do_read(8'h00);
    do_read(8'h02);
    do_read(8'h04);

    // Start pulse while waiting for a low byte restarts at pointer 0.
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    ref_mem[0] = 16'h1122;
    pulse_start();
    @(negedge CLK);
    chk("restart_words", bus.WORDS_LOADED, 0);
    chk("restart_ready", bus.LD_READY, 1);
    chk("restart_err", bus.LD_ERR, 0);
    @(posedge CLK); #1;
    sess_words = '{16'h4455};
    run_session(0, 1'b0, 1'b0);
    do_read(8'h00);
    do_read(8'h02);

    // Exactly full array with LAST on the final word: no error.
    sess_words.delete();
    for (int i = 0; i < 128; i++) sess_words.push_back(16'($urandom));
    run_session(127, 1'b0, 1'b1);
    do_read(8'h00);
    do_read(8'hFE);
    do_read(8'h81);

`ifdef IRAM_LOAD_CHECKSUM_EN
    sess_words = '{16'h0001, 16'h0002};
    run_session(1, 1'b0, 1'b1);
    sess_words = '{16'h0001, 16'h0002};
    run_session(1, 1'b1, 1'b1);
`endif

    // Random short sessions followed by random fetches.
    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(1, 6);
      sess_words.delete();
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        sess_words.push_back(w);
      end
      run_session(n - 1, ($urandom_range(0, 3) == 0), 1'b1);
      repeat (4) do_read(8'($urandom));
    end

    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("done_queue_drained", done_exp.size(), 0);
    chk("fetch_queue_drained", rd_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
